mac_array_ctrl: RTL and testbench
=================================

// Module: mac_array_ctrl
// PURPOSE
//  Sequencer for the mac_col array (col columns of pr-lane MACs) and its operand SRAM.
//  On start it streams key vectors to the array (load phase), then query vectors (execute phase).
//  It then waits until the last column's fifo_wr pulses show every result written to the output FIFO.
//  Sits between the top-level core FSM and the array/SRAM; owns inst[1:0] and SRAM read control.
// PARAMETERS
//  col      8   number of mac_col instances fed by inst (daisy-chained via o_inst)
//  addr_w   4   query index width; SRAM address is addr_w+1 bits (MSB 0 = key region, 1 = query region)
//  load_len 10  load-phase length in cycles (key vectors streamed; covers col_id 0 count 0..9)
//  drain_max 32 DRAIN-state timeout in cycles
// PORTS
//  clk          in  1        rising-edge clock
//  reset        in  1        asynchronous, active-low reset
//  start        in  1        1-cycle request; sampled only in IDLE
//  num_q        in  addr_w   query vectors to execute; sampled with start
//  ofifo_afull  in  1        output FIFO almost-full (>= col+3 free slots when low)
//  col_fifo_wr  in  col      fifo_wr taps of all columns; only bit [col-1] is counted
//  inst         out 2        [1] execute, [0] load; drives mac_col 0 i_inst
//  mem_cen      out 1        SRAM read enable, active-high
//  mem_addr     out addr_w+1 SRAM read address
//  busy         out 1        high in LOAD/EXEC/DRAIN
//  done         out 1        1-cycle pulse at end of run
//  err          out 1        sticky drain timeout; cleared by next accepted start
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; inst=00, mem_cen=0, mem_addr=0, busy=0, done=0, err=0; counters 0.
//  All outputs registered. inst, mem_cen and mem_addr change on the same edge, so 1-cycle SRAM data meets
//   the inst_q stage inside mac_col.
//  IDLE : start=1 -> latch num_q into nq_q, clear err, go LOAD next edge. start in any other state ignored.
//  LOAD : inst=01, mem_cen=1, mem_addr={1'b0,k}, k=0..load_len-1, one per cycle; after k=load_len-1 ->
//         EXEC if nq_q!=0, else DRAIN (no query issued; drain ends on the wr count of 0).
//  EXEC : per cycle, if ofifo_afull=0: inst=10, mem_cen=1, mem_addr={1'b1,q}, q++.
//         If ofifo_afull=1: bubble (inst=00, mem_cen=0, q held); resumes the cycle after afull drops.
//         After issuing q=nq_q-1 -> DRAIN. Never back-to-back load after execute within a run.
//  DRAIN: inst=00, mem_cen=0. Counter wr_cnt (addr_w+1 bits) counts col_fifo_wr[col-1] pulses from
//         EXEC entry onward, including pulses seen during EXEC. When wr_cnt==nq_q -> DONE.
//         Timeout counter counts DRAIN cycles; reaching drain_max -> err=1, DONE.
//  DONE : done=1 for exactly one cycle, busy=0 -> IDLE. start in DONE is ignored.
//  Extra last-column pulses beyond nq_q are ignored (wr_cnt saturates at nq_q).
//  Pulses on col_fifo_wr outside EXEC/DRAIN are ignored.
//  Reset asserted mid-run: immediate return to reset values. inst drops to 00 asynchronously; the array is
//   left partially loaded, and the next run reloads all keys.
//  Max run: nq_q=2^addr_w-1; the q counter must not wrap into the key region.
// TESTING
//  Reset: hold reset=0 for 3 clk -> inst=00, mem_cen=0, busy=0, done=0, err=0.
//  Nominal: start, num_q=4, afull=0, pulses on col_fifo_wr[7] emulated 4 cycles after each execute ->
//   10 cycles inst=01 addr 0x00..0x09; 4 cycles inst=10 addr 0x10..0x13; done pulses once after the 4th wr.
//  Backpressure: num_q=6, afull high for 3 cycles after the 2nd query -> 3 bubbles with inst=00, then
//   addr 0x12..0x15 with no skip or repeat.
//  Zero queries: num_q=0 -> LOAD 10 cycles, no inst=10 cycle, done 1 cycle after DRAIN entry, err=0.
//  Start while busy, then reset low mid-EXEC -> start ignored; all outputs 0 immediately; a new start
//   re-runs LOAD from addr 0.
//  Timeout: num_q=3, only 2 wr pulses -> done exactly drain_max cycles after DRAIN entry, err=1 until next start.

Source files
------------

// File: rtl/mac_array_ctrl.sv
// Sequencer for the mac_col array and its operand SRAM: streams key vectors (load),
// then query vectors (execute), then waits for the last column to write every result.
module mac_array_ctrl #(
    parameter int COL       = 8,
    parameter int ADDR_W    = 4,
    parameter int LOAD_LEN  = 10,
    parameter int DRAIN_MAX = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_num_q,
    input  logic              i_ofifo_afull,
    input  logic [COL-1:0]    i_col_fifo_wr,
    output logic [1:0]        o_inst,
    output logic              o_mem_cen,
    output logic [ADDR_W:0]   o_mem_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [2:0]        o_dbg_state
);

    localparam int K_W  = $clog2(LOAD_LEN + 1);
    localparam int TO_W = $clog2(DRAIN_MAX + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        r_state, w_state;
    logic [K_W-1:0]    r_k, w_k;
    logic [ADDR_W-1:0] r_q, w_q;
    logic [ADDR_W-1:0] r_nq, w_nq;
    logic [ADDR_W:0]   r_wr_cnt, w_wr_cnt;
    logic [TO_W-1:0]   r_to, w_to;
    logic [1:0]        r_inst, w_inst;
    logic              r_cen, w_cen;
    logic [ADDR_W:0]   r_addr, w_addr;
    logic              r_busy, w_busy;
    logic              r_done, w_done;
    logic              r_err, w_err;
    logic              w_try_issue;
    logic              w_wr_hit;
    logic [ADDR_W:0]   w_wr_next;
    logic              w_unused_taps;

    // Only the last column's write tap marks a finished result.
    assign w_unused_taps = ^i_col_fifo_wr[COL-2:0];

    // Saturating count of last-column writes, live only from EXEC onward.
    assign w_wr_hit  = i_col_fifo_wr[COL-1] && ((r_state == S_EXEC) || (r_state == S_DRAIN))
                       && (r_wr_cnt < {1'b0, r_nq});
    assign w_wr_next = w_wr_hit ? (r_wr_cnt + (ADDR_W+1)'(1)) : r_wr_cnt;

    // Handshake: i_start is a one-cycle request, accepted only in IDLE (i_num_q captured with it);
    // in every other state it is dropped without effect. Outputs are computed here and registered,
    // so inst, cen and addr always leave the flops on the same edge.
    always_comb begin
        w_state     = r_state;
        w_k         = r_k;
        w_q         = r_q;
        w_nq        = r_nq;
        w_wr_cnt    = w_wr_next;
        w_to        = r_to;
        w_inst      = 2'b00;
        w_cen       = 1'b0;
        w_addr      = '0;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_err       = r_err;
        w_try_issue = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_wr_cnt = '0;
                if (i_start) begin
                    w_state = S_LOAD;
                    w_nq    = i_num_q;
                    w_err   = 1'b0;
                    w_k     = '0;
                    w_q     = '0;
                    w_to    = '0;
                    w_inst  = 2'b01;
                    w_cen   = 1'b1;
                    w_busy  = 1'b1;
                end
            end
            S_LOAD: begin
                if (r_k == K_W'(LOAD_LEN - 1)) begin
                    w_to = '0;
                    if (r_nq != '0) begin
                        w_state     = S_EXEC;
                        w_try_issue = 1'b1;
                    end else begin
                        w_state = S_DRAIN;
                    end
                end else begin
                    w_k    = r_k + K_W'(1);
                    w_inst = 2'b01;
                    w_cen  = 1'b1;
                    w_addr = {1'b0, ADDR_W'(r_k + K_W'(1))};
                end
            end
            S_EXEC: begin
                if (r_q == r_nq) begin
                    w_state = S_DRAIN;
                    w_to    = '0;
                end else begin
                    w_try_issue = 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_wr_next == {1'b0, r_nq}) begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                end else if (r_to == TO_W'(DRAIN_MAX - 1)) begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_err   = 1'b1;
                end else begin
                    w_to = r_to + TO_W'(1);
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
        endcase

        // q only advances on an issued query, so a bubble never skips or repeats an address.
        if (w_try_issue && !i_ofifo_afull) begin
            w_inst = 2'b10;
            w_cen  = 1'b1;
            w_addr = {1'b1, r_q};
            w_q    = r_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_q      <= '0;
            r_nq     <= '0;
            r_wr_cnt <= '0;
            r_to     <= '0;
            r_inst   <= 2'b00;
            r_cen    <= 1'b0;
            r_addr   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_k      <= w_k;
            r_q      <= w_q;
            r_nq     <= w_nq;
            r_wr_cnt <= w_wr_cnt;
            r_to     <= w_to;
            r_inst   <= w_inst;
            r_cen    <= w_cen;
            r_addr   <= w_addr;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_err    <= w_err;
        end
    end

    assign o_inst      = r_inst;
    assign o_mem_cen   = r_cen;
    assign o_mem_addr  = r_addr;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Randomized bench for mac_array_ctrl: a run-level model predicts the full output trace
// (issue slots, drain completion or timeout) from num_q, the afull pattern and the write pulses.
module tb_mac_array_ctrl;

    localparam int COL       = 8;
    localparam int ADDR_W    = 4;
    localparam int LOAD_LEN  = 10;
    localparam int DRAIN_MAX = 32;
    localparam int MAXT      = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] num_q = '0;
    logic              afull = 1'b0;
    logic [COL-1:0]    fwr = '0;
    logic [1:0]        o_inst;
    logic              o_mem_cen;
    logic [ADDR_W:0]   o_mem_addr;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic [2:0]        o_dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [ADDR_W:0] exp_q[$];

    always #5 clk = ~clk;

    mac_array_ctrl #(
        .COL(COL), .ADDR_W(ADDR_W), .LOAD_LEN(LOAD_LEN), .DRAIN_MAX(DRAIN_MAX)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_q(num_q),
        .i_ofifo_afull(afull), .i_col_fifo_wr(fwr),
        .o_inst(o_inst), .o_mem_cen(o_mem_cen), .o_mem_addr(o_mem_addr),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_dbg_state(o_dbg_state)
    );

    function automatic logic [10:0] obs();
        return {o_inst, o_mem_cen, o_mem_addr, o_busy, o_done, o_err};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One run: build stimulus, predict the trace, drive it and compare every cycle.
    // Cycle t = state of the outputs just after the t-th edge counted from the start edge.
    task automatic run(input int nq, input int af_mode, input int drop_mode, input int pdly,
                       input int abort_at);
        bit   af[MAXT];
        bit   pw[MAXT];
        bit   st[MAXT];
        int   is_at[MAXT];
        int   iss[$];
        int   d_e, done_e, cnt, t;
        bit   err_x, keep;
        logic [10:0] ev;
        logic [31:0] exp_addr;

        for (int i = 0; i < MAXT; i++) begin
            if (af_mode == 2) af[i] = (i < 150) && ($urandom_range(99) < 25);
            else              af[i] = (af_mode == 1) && (i >= 12) && (i <= 14);
            pw[i]    = 1'b0;
            is_at[i] = -1;
            st[i]    = (i > 0) && ($urandom_range(99) < 10);
        end
        t = LOAD_LEN;
        while (iss.size() < nq) begin
            if (!af[t]) begin
                is_at[t] = iss.size();
                iss.push_back(t);
            end
            t++;
        end
        for (int i = 0; i < nq; i++) begin
            keep = (drop_mode == 0) || (drop_mode == 1 && i != nq - 1) ||
                   (drop_mode == 2 && $urandom_range(99) < 80);
            if (keep) pw[iss[i] + ((pdly != 0) ? pdly : $urandom_range(1, 6))] = 1'b1;
        end
        if ($urandom_range(1) == 1) pw[$urandom_range(1, LOAD_LEN)] = 1'b1;

        d_e    = (nq == 0) ? LOAD_LEN : iss[nq-1] + 1;
        cnt    = 0;
        done_e = -1;
        err_x  = 1'b0;
        for (int e = LOAD_LEN + 1; e <= d_e + DRAIN_MAX && done_e < 0; e++) begin
            if (pw[e]) cnt++;
            if (e > d_e) begin
                if (cnt >= nq) done_e = e;
                else if (e == d_e + DRAIN_MAX) begin
                    done_e = e;
                    err_x  = 1'b1;
                end
            end
        end

        exp_q.delete();
        for (int k = 0; k < LOAD_LEN; k++) exp_q.push_back({1'b0, ADDR_W'(k)});
        for (int i = 0; i < nq; i++)       exp_q.push_back({1'b1, ADDR_W'(i)});

        for (t = 0; t <= done_e + 1; t++) begin
            start = (t == 0) ? 1'b1 : st[t];
            num_q = (t == 0) ? ADDR_W'(nq) : ADDR_W'($urandom);
            afull = af[t];
            fwr   = {pw[t], 7'($urandom)};
            @(posedge clk);
            #1;
            if (t < LOAD_LEN)        ev[10:3] = {2'b01, 1'b1, 1'b0, ADDR_W'(t)};
            else if (is_at[t] >= 0)  ev[10:3] = {2'b10, 1'b1, 1'b1, ADDR_W'(is_at[t])};
            else                     ev[10:3] = '0;
            ev[2] = (t < done_e);
            ev[1] = (t == done_e);
            ev[0] = (t >= done_e) && err_x;
            check_eq($sformatf("nq%0d_cyc%0d", nq, t), 32'(obs()), 32'(ev));
            if (o_mem_cen) begin
                exp_addr = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
                check_eq($sformatf("sram_addr_cyc%0d", t), 32'(o_mem_addr), exp_addr);
            end
            if (t == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check_eq("rst_async", 32'(obs()), 32'd0);
                start = 1'b0;
                afull = 1'b0;
                fwr   = '0;
                exp_q.delete();
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
        end
        start = 1'b0;
        afull = 1'b0;
        fwr   = '0;
        check_eq("sram_all_issued", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_eq("reset", 32'(obs()), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(4, 0, 0, 4, -1);
        run(6, 1, 0, 4, -1);
        run(0, 0, 0, 4, -1);
        run(8, 0, 0, 4, 12);
        run(5, 0, 0, 4, -1);
        run(3, 0, 1, 4, -1);
        run(2, 0, 0, 3, -1);
        run(15, 0, 0, 4, -1);
        for (int r = 0; r < 20; r++)
            run($urandom_range(0, 15), 2, ($urandom_range(1) == 1) ? 2 : 0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
